// File: rtl/btb_predictor_if.sv
// btb_predictor_if: fetch/execute-side signal bundle between the pipeline and the branch predictor
interface btb_predictor_if #(parameter int CNT_W = 16);
  logic             memory_stall;
  logic [31:0]      instructionPC_1;
  logic             taken;
  logic [31:0]      branchPC;
  logic             flush;
  logic [31:0]      instructionPC_3;
  logic             is_branchInst_3;
  logic             taken_3;
  logic             prev_taken_3;
  logic [31:0]      target_3;
  logic [CNT_W-1:0] mispredict_cnt;
  modport master (
    output memory_stall, instructionPC_1, instructionPC_3, is_branchInst_3, taken_3, prev_taken_3, target_3,
    input  taken, branchPC, flush, mispredict_cnt
  );
  modport slave (
    input  memory_stall, instructionPC_1, instructionPC_3, is_branchInst_3, taken_3, prev_taken_3, target_3,
    output taken, branchPC, flush, mispredict_cnt
  );
endinterface

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with saturating-counter prediction and EX-stage misprediction recovery
module btb_predictor #(
  parameter int ENTRIES   = 32,
  parameter int TAG_W     = 30 - $clog2(ENTRIES),
  parameter int CTR_W     = 2,
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 16
) (
  input logic            clk,
  input logic            rst_n,
  btb_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] WEAK_T = CTR_W'(1) << (CTR_W - 1);
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx1, idx3;
  logic [TAG_W-1:0] tag1, tag3;
  logic             hit1, hit3, flush, alias_hit;
  logic [31:0]      rec_pc;
  logic [CTR_W-1:0] ctr_d;
  assign idx1 = bus.instructionPC_1[IDX_W+1:2];
  assign tag1 = bus.instructionPC_1[IDX_W+1+TAG_W:IDX_W+2];
  assign idx3 = bus.instructionPC_3[IDX_W+1:2];
  assign tag3 = bus.instructionPC_3[IDX_W+1+TAG_W:IDX_W+2];
  // Lookup sees pre-update table contents; resolve is purely a function of EX inputs
  always_comb begin
    hit1      = valid_q[idx1] && (tag_q[idx1] == tag1);
    hit3      = valid_q[idx3] && (tag_q[idx3] == tag3);
    alias_hit = !bus.is_branchInst_3 && bus.prev_taken_3;
    flush     = (bus.is_branchInst_3 && (bus.taken_3 != bus.prev_taken_3)) || alias_hit;
    rec_pc    = (bus.is_branchInst_3 && bus.taken_3) ? bus.target_3 : bus.instructionPC_3 + 32'd4;
    ctr_d     = bus.taken_3 ? ((&ctr_q[idx3]) ? ctr_q[idx3] : ctr_q[idx3] + CTR_W'(1))
                            : ((|ctr_q[idx3]) ? ctr_q[idx3] - CTR_W'(1) : ctr_q[idx3]);
    cnt_d     = (flush && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign bus.taken          = (PRED_MODE != 0) && hit1 && ctr_q[idx1][CTR_W-1];
  assign bus.flush          = flush;
  assign bus.branchPC       = flush ? rec_pc : tgt_q[idx1];
  assign bus.mispredict_cnt = cnt_q;
  // Table and mispredict counter update once per unstalled cycle; reset empties the table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= '0;
      end
      cnt_q <= '0;
    end else if (!bus.memory_stall) begin
      cnt_q <= cnt_d;
      if (bus.is_branchInst_3 && hit3) begin
        ctr_q[idx3] <= ctr_d;
        if (bus.taken_3) tgt_q[idx3] <= bus.target_3;
      end else if (bus.is_branchInst_3 && bus.taken_3) begin
        valid_q[idx3] <= 1'b1;
        tag_q[idx3]   <= tag3;
        tgt_q[idx3]   <= bus.target_3;
        ctr_q[idx3]   <= WEAK_T;
      end else if (alias_hit) begin
        valid_q[idx3] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed + random checks of three predictor configurations against a table model
module tb_btb_predictor;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic stall = 0, br = 0, t3 = 0, p3 = 0;
  logic [31:0] pc1 = 0, pc3 = 0, tgt3 = 0;
  int ncmp = 0, nfail = 0;
  btb_predictor_if #(.CNT_W(16)) if0();
  btb_predictor_if #(.CNT_W(2))  if1();
  btb_predictor_if #(.CNT_W(16)) if2();
  assign if0.memory_stall = stall; assign if0.instructionPC_1 = pc1; assign if0.instructionPC_3 = pc3;
  assign if0.is_branchInst_3 = br; assign if0.taken_3 = t3; assign if0.prev_taken_3 = p3; assign if0.target_3 = tgt3;
  assign if1.memory_stall = stall; assign if1.instructionPC_1 = pc1; assign if1.instructionPC_3 = pc3;
  assign if1.is_branchInst_3 = br; assign if1.taken_3 = t3; assign if1.prev_taken_3 = p3; assign if1.target_3 = tgt3;
  assign if2.memory_stall = stall; assign if2.instructionPC_1 = pc1; assign if2.instructionPC_3 = pc3;
  assign if2.is_branchInst_3 = br; assign if2.taken_3 = t3; assign if2.prev_taken_3 = p3; assign if2.target_3 = tgt3;
  btb_predictor u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  btb_predictor #(.ENTRIES(4), .TAG_W(1), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  btb_predictor #(.PRED_MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  localparam int IW [3] = '{5, 2, 5};
  localparam int TW [3] = '{25, 1, 25};
  localparam int PM [3] = '{1, 1, 0};
  localparam int CMAX [3] = '{65535, 3, 65535};
  bit          mv   [3][32];
  logic [31:0] mtg  [3][32];
  logic [31:0] mtgt [3][32];
  int          mc   [3][32];
  int          mcnt [3];
  function automatic int mi(int k, logic [31:0] pc);
    return int'((pc >> 2) % (32'd1 << IW[k]));
  endfunction
  function automatic logic [31:0] mt(int k, logic [31:0] pc);
    return (pc >> (2 + IW[k])) % (32'd1 << TW[k]);
  endfunction
  function automatic bit fl_e();
    return (br && (t3 != p3)) || (!br && p3);
  endfunction
  function automatic logic [31:0] rec_e();
    return (br && t3) ? tgt3 : pc3 + 32'd4;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      for (int e = 0; e < 32; e++) begin
        mv[k][e] = 0; mtg[k][e] = 0; mtgt[k][e] = 0; mc[k][e] = 0;
      end
    end
  endtask
  task automatic model_update();
    if (stall) return;
    for (int k = 0; k < 3; k++) begin
      int i = mi(k, pc3);
      bit hit = mv[k][i] && (mtg[k][i] == mt(k, pc3));
      if (br && hit) begin
        if (t3) begin
          mc[k][i] = (mc[k][i] < 3) ? mc[k][i] + 1 : 3;
          mtgt[k][i] = tgt3;
        end else mc[k][i] = (mc[k][i] > 0) ? mc[k][i] - 1 : 0;
      end else if (br && t3) begin
        mv[k][i] = 1; mtg[k][i] = mt(k, pc3); mtgt[k][i] = tgt3; mc[k][i] = 2;
      end else if (!br && p3) mv[k][i] = 0;
      if (fl_e() && mcnt[k] < CMAX[k]) mcnt[k]++;
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int i = mi(k, pc1);
      logic [31:0] tk, bp, fl, cn;
      bit et = (PM[k] != 0) && mv[k][i] && (mtg[k][i] == mt(k, pc1)) && (mc[k][i] >= 2);
      tk = (k == 0) ? 32'(if0.taken) : (k == 1) ? 32'(if1.taken) : 32'(if2.taken);
      bp = (k == 0) ? if0.branchPC : (k == 1) ? if1.branchPC : if2.branchPC;
      fl = (k == 0) ? 32'(if0.flush) : (k == 1) ? 32'(if1.flush) : 32'(if2.flush);
      cn = (k == 0) ? 32'(if0.mispredict_cnt) : (k == 1) ? 32'(if1.mispredict_cnt) : 32'(if2.mispredict_cnt);
      chk($sformatf("u%0d.taken", k), tk, 32'(et));
      chk($sformatf("u%0d.flush", k), fl, 32'(fl_e()));
      chk($sformatf("u%0d.branchPC", k), bp, fl_e() ? rec_e() : mtgt[k][i]);
      chk($sformatf("u%0d.cnt", k), cn, 32'(mcnt[k]));
    end
  endtask
  task automatic drive(bit s, logic [31:0] f, logic [31:0] e, bit b, bit t, bit p, logic [31:0] g);
    stall = s; pc1 = f; pc3 = e; br = b; t3 = t; p3 = p; tgt3 = g;
  endtask
  task automatic step();
    @(negedge clk);
    check_all();
    if (rst_n) model_update();
    @(posedge clk);
    #1;
  endtask
  int c0;
  initial begin
    model_reset();
    drive(0, 32'h100, 32'h100, 1, 1, 0, 32'h40);
    step();
    chk("rst_taken", 32'(if0.taken), 0);
    chk("rst_flush_ex_only", 32'(if0.flush), 1);
    rst_n = 1'b1;
    drive(0, 32'h100, 32'h100, 1, 0, 0, 32'h0);
    step();
    chk("t1_no_flush", 32'(if0.flush), 0);
    chk("t1_no_alloc", 32'(if0.taken), 0);
    drive(0, 32'h0, 32'h100, 1, 1, 0, 32'h40);
    step();
    chk("t2_flush", 32'(if0.flush), 1);
    chk("t2_branchPC", if0.branchPC, 32'h40);
    chk("t2_cnt", 32'(if0.mispredict_cnt), 1);
    drive(0, 32'h100, 32'h0, 0, 0, 0, 32'h0);
    #1;
    chk("t2_fetch_taken", 32'(if0.taken), 1);
    chk("t2_fetch_target", if0.branchPC, 32'h40);
    chk("t2_static_taken", 32'(if2.taken), 0);
    step();
    drive(0, 32'h100, 32'h100, 1, 0, 1, 32'h0);
    #1;
    chk("t3_flush", 32'(if0.flush), 1);
    chk("t3_recovery", if0.branchPC, 32'h104);
    step();
    drive(0, 32'h100, 32'h100, 1, 0, 0, 32'h0);
    #1;
    chk("t3_second_no_flush", 32'(if0.flush), 0);
    step();
    chk("t3_ctr_zero", 32'(if0.taken), 0);
    c0 = int'(if0.mispredict_cnt);
    drive(1, 32'h100, 32'h100, 1, 1, 0, 32'h40);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t4_stall_flush", 32'(if0.flush), 1);
      chk("t4_stall_cnt_hold", 32'(if0.mispredict_cnt), 32'(c0));
    end
    stall = 0;
    step();
    chk("t4_cnt_once", 32'(if0.mispredict_cnt), 32'(c0 + 1));
    drive(0, 32'h0, 32'h0, 1, 1, 0, 32'h80);
    step();
    step();
    drive(0, 32'h20, 32'h0, 0, 0, 0, 32'h0);
    #1;
    chk("t5_alias_taken", 32'(if1.taken), 1);
    chk("t5_full_tag_miss", 32'(if0.taken), 0);
    step();
    drive(0, 32'h0, 32'h20, 0, 0, 1, 32'h0);
    #1;
    chk("t5_alias_flush", 32'(if1.flush), 1);
    chk("t5_alias_recovery", if1.branchPC, 32'h24);
    step();
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    #1;
    chk("t5_invalidated", 32'(if1.taken), 0);
    step();
    drive(0, 32'h0, 32'hFFFF_FFFC, 0, 0, 1, 32'h0);
    #1;
    chk("wrap_recovery", if0.branchPC, 32'h0);
    step();
    chk("t6_cnt_sat", 32'(if1.mispredict_cnt), 3);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 63) << 2) | (32'($urandom_range(0, 1)) << 31);
      b = ($urandom_range(0, 63) << 2) | (32'($urandom_range(0, 1)) << 31);
      drive($urandom_range(0, 4) == 0, a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC);
      if (n == 300) begin
        drive(0, b, b, 1, 1, 0, 32'h1234);
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        drive(0, b, 32'h0, 0, 0, 0, 32'h0);
        #1;
        chk("midrst_empty", 32'(if0.taken), 0);
        chk("midrst_cnt", 32'(if0.mispredict_cnt), 0);
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
